pwm_gate_monitor: RTL and testbench

Receive-side checker for the six inverter gate signals produced by the PWM modulator/deadtime/gate-block chain. Per carrier period, it measures:
- the upper-switch on-time of each phase;
- the carrier period length;
- the shortest dead interval actually present on any leg.

It raises sticky faults for shoot-through, deadtime violation and loss of carrier synchronisation. It sits beside the modulator in the same clock domain and feeds the protection logic and the telemetry registers.

---
 rtl/pwm_gate_monitor.sv | 193 +++++++++++++++++++
 tb/tb_pwm_gate_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gate_monitor.sv
// Receive-side checker for six inverter gate signals: measures per-period on-times,
// carrier period length and shortest dead interval, and latches sticky gate faults.
module pwm_gate_monitor #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             U,
    input  logic             V,
    input  logic             W,
    input  logic             X,
    input  logic             Y,
    input  logic             Z,
    input  logic             CARRIER_PEAK,
    input  logic [CNT_W-1:0] PRM_DEADTIME,
    input  logic             FAULT_CLR,
    output logic [CNT_W-1:0] DUTY_U,
    output logic [CNT_W-1:0] DUTY_V,
    output logic [CNT_W-1:0] DUTY_W,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] DT_MIN,
    output logic             VALID,
    output logic             FAULT,
    output logic [2:0]       FAULT_SRC
);

    localparam int unsigned      NLEG    = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_WAIT_SYNC = 1'b0,
        ST_RUN       = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [NLEG-1:0]  s_up_q, s_up_d, s_lo_q, s_lo_d;
    logic             s_peak_q, s_peak_d, s_vld_q, s_vld_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] on_q [NLEG];
    logic [CNT_W-1:0] on_d [NLEG];
    logic [CNT_W-1:0] dcnt_q [NLEG];
    logic [CNT_W-1:0] dcnt_d [NLEG];
    logic [CNT_W-1:0] run_min_q, run_min_d;
    logic [CNT_W-1:0] duty_q [NLEG];
    logic [CNT_W-1:0] duty_d [NLEG];
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] dt_min_q, dt_min_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    logic [2:0]       fault_src_q, fault_src_d;

    logic             ovf_c, shoot_c, dt_short_c, publish_c;
    logic [CNT_W-1:0] close_min_c;

    // Input sample stage; s_vld marks that S holds a real sample rather than reset zeros.
    always_comb begin
        s_up_d   = {W, V, U};
        s_lo_d   = {Z, Y, X};
        s_peak_d = CARRIER_PEAK;
        s_vld_d  = 1'b1;
    end

    // Period, on-time and dead-interval measurement on the sampled gates.
    always_comb begin
        ovf_c = 1'b0;
        if (s_peak_q) begin
            pcnt_d = CNT_ONE;
        end else if (pcnt_q == CNT_MAX) begin
            pcnt_d = pcnt_q;
        end else begin
            pcnt_d = pcnt_q + CNT_ONE;
            ovf_c  = (pcnt_d == CNT_MAX);
        end

        shoot_c     = |(s_up_q & s_lo_q);
        dt_short_c  = 1'b0;
        close_min_c = CNT_MAX;
        for (int i = 0; i < int'(NLEG); i++) begin
            if (s_peak_q) begin
                on_d[i] = {{(CNT_W-1){1'b0}}, s_up_q[i]};
            end else if (s_up_q[i] && (on_q[i] != CNT_MAX)) begin
                on_d[i] = on_q[i] + CNT_ONE;
            end else begin
                on_d[i] = on_q[i];
            end

            if (s_vld_q && !s_up_q[i] && !s_lo_q[i]) begin
                dcnt_d[i] = (dcnt_q[i] == CNT_MAX) ? dcnt_q[i] : dcnt_q[i] + CNT_ONE;
            end else begin
                dcnt_d[i] = '0;
            end

            // Exactly one switch on after a dead run closes the interval.
            if ((s_up_q[i] ^ s_lo_q[i]) && (dcnt_q[i] != '0)) begin
                if (dcnt_q[i] < close_min_c) begin
                    close_min_c = dcnt_q[i];
                end
                if (dcnt_q[i] < PRM_DEADTIME) begin
                    dt_short_c = 1'b1;
                end
            end
        end

        // A close in the peak cycle belongs to the new period.
        if (s_peak_q || (close_min_c < run_min_q)) begin
            run_min_d = close_min_c;
        end else begin
            run_min_d = run_min_q;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_WAIT_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_SYNC: if (s_peak_q) state_d = ST_RUN;
            ST_RUN:       if (ovf_c)    state_d = ST_WAIT_SYNC;
            default:      state_d = ST_WAIT_SYNC;
        endcase
    end

    // FSM outputs: publish on a peak while synchronised; sticky faults with set priority.
    always_comb begin
        publish_c = (state_q == ST_RUN) && s_peak_q;
        for (int i = 0; i < int'(NLEG); i++) begin
            duty_d[i] = publish_c ? on_q[i] : duty_q[i];
        end
        period_d    = publish_c ? pcnt_q : period_q;
        dt_min_d    = publish_c ? run_min_q : dt_min_q;
        valid_d     = publish_c;
        fault_src_d = (fault_src_q & ~{3{FAULT_CLR}}) | {ovf_c, dt_short_c, shoot_c};
        fault_d     = |fault_src_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s_up_q      <= '0;
            s_lo_q      <= '0;
            s_peak_q    <= 1'b0;
            s_vld_q     <= 1'b0;
            pcnt_q      <= '0;
            run_min_q   <= CNT_MAX;
            period_q    <= '0;
            dt_min_q    <= CNT_MAX;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
            fault_src_q <= '0;
            for (int i = 0; i < int'(NLEG); i++) begin
                on_q[i]   <= '0;
                dcnt_q[i] <= '0;
                duty_q[i] <= '0;
            end
        end else begin
            s_up_q      <= s_up_d;
            s_lo_q      <= s_lo_d;
            s_peak_q    <= s_peak_d;
            s_vld_q     <= s_vld_d;
            pcnt_q      <= pcnt_d;
            run_min_q   <= run_min_d;
            period_q    <= period_d;
            dt_min_q    <= dt_min_d;
            valid_q     <= valid_d;
            fault_q     <= fault_d;
            fault_src_q <= fault_src_d;
            for (int i = 0; i < int'(NLEG); i++) begin
                on_q[i]   <= on_d[i];
                dcnt_q[i] <= dcnt_d[i];
                duty_q[i] <= duty_d[i];
            end
        end
    end

    assign DUTY_U    = duty_q[0];
    assign DUTY_V    = duty_q[1];
    assign DUTY_W    = duty_q[2];
    assign PERIOD    = period_q;
    assign DT_MIN    = dt_min_q;
    assign VALID     = valid_q;
    assign FAULT     = fault_q;
    assign FAULT_SRC = fault_src_q;

endmodule

// File: tb/tb_pwm_gate_monitor.sv
// Directed bench for pwm_gate_monitor: 100-cycle carrier periods with fixed gate patterns.
module tb_pwm_gate_monitor;

    localparam int unsigned CNT_W = 8;
    localparam int          NPOS  = 100;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             U, V, W, X, Y, Z;
    logic             CARRIER_PEAK;
    logic [CNT_W-1:0] PRM_DEADTIME;
    logic             FAULT_CLR;
    logic [CNT_W-1:0] DUTY_U, DUTY_V, DUTY_W, PERIOD, DT_MIN;
    logic             VALID, FAULT;
    logic [2:0]       FAULT_SRC;

    int n_vec  = 0;
    int n_miss = 0;

    logic [CNT_W-1:0] lg_duty_u [NPOS];
    logic [CNT_W-1:0] lg_duty_v [NPOS];
    logic [CNT_W-1:0] lg_duty_w [NPOS];
    logic [CNT_W-1:0] lg_period [NPOS];
    logic [CNT_W-1:0] lg_dtmin  [NPOS];
    logic             lg_valid  [NPOS];
    logic             lg_fault  [NPOS];
    logic [2:0]       lg_src    [NPOS];

    pwm_gate_monitor #(.CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .U            (U),
        .V            (V),
        .W            (W),
        .X            (X),
        .Y            (Y),
        .Z            (Z),
        .CARRIER_PEAK (CARRIER_PEAK),
        .PRM_DEADTIME (PRM_DEADTIME),
        .FAULT_CLR    (FAULT_CLR),
        .DUTY_U       (DUTY_U),
        .DUTY_V       (DUTY_V),
        .DUTY_W       (DUTY_W),
        .PERIOD       (PERIOD),
        .DT_MIN       (DT_MIN),
        .VALID        (VALID),
        .FAULT        (FAULT),
        .FAULT_SRC    (FAULT_SRC)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // U: on 0..39, dead 5 (3 if short), X on to 94, dead 95..99.
    // V: on 0..59, dead 60..65, Y on 66..93, dead 94..99.
    // W: on 0..19, dead 20..26, Z on 27..92, dead 93..99.
    function automatic logic [5:0] gates(input int pos, input bit short_u, input bit w_en);
        logic u, v, w, x, y, z;
        u = (pos < 40);
        x = short_u ? (pos >= 43 && pos < 95) : (pos >= 45 && pos < 95);
        v = (pos < 60);
        y = (pos >= 66 && pos < 94);
        w = w_en && (pos < 20);
        z = w_en && (pos >= 27 && pos < 93);
        return {u, v, w, x, y, z};
    endfunction

    task automatic drive_cycle(input int pos, input bit peak, input bit short_u, input bit w_en,
                               input bit rst, input bit clr, input bit shoot_v);
        logic [5:0] g;
        g = gates(pos, short_u, w_en);
        {U, V, W, X, Y, Z} = g;
        if (shoot_v) begin
            V = 1'b1;
            Y = 1'b1;
        end
        CARRIER_PEAK = peak;
        RESET        = rst;
        FAULT_CLR    = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_period(input bit peak2, input bit short_u, input bit w_en, input int rst_pos,
                              input int clr_a, input int clr_b, input int shoot_a, input int shoot_b);
        for (int pos = 0; pos < NPOS; pos++) begin
            drive_cycle(pos, (pos == 0) || (peak2 && pos == 1), short_u, w_en, pos == rst_pos,
                        (pos == clr_a) || (pos == clr_b), (pos == shoot_a) || (pos == shoot_b));
            lg_duty_u[pos] = DUTY_U;
            lg_duty_v[pos] = DUTY_V;
            lg_duty_w[pos] = DUTY_W;
            lg_period[pos] = PERIOD;
            lg_dtmin[pos]  = DT_MIN;
            lg_valid[pos]  = VALID;
            lg_fault[pos]  = FAULT;
            lg_src[pos]    = FAULT_SRC;
        end
    endtask

    function automatic int vcount();
        int c = 0;
        for (int i = 0; i < NPOS; i++) if (lg_valid[i]) c++;
        return c;
    endfunction

    task automatic check_pub(input string tag, input int idx, input int du, input int dv, input int dw,
                             input int per, input int dtm, input int src);
        check_val({tag, "_valid"},  32'(lg_valid[idx]),  1);
        check_val({tag, "_duty_u"}, 32'(lg_duty_u[idx]), 32'(du));
        check_val({tag, "_duty_v"}, 32'(lg_duty_v[idx]), 32'(dv));
        check_val({tag, "_duty_w"}, 32'(lg_duty_w[idx]), 32'(dw));
        check_val({tag, "_period"}, 32'(lg_period[idx]), 32'(per));
        check_val({tag, "_dt_min"}, 32'(lg_dtmin[idx]),  32'(dtm));
        check_val({tag, "_src"},    32'(lg_src[idx]),    32'(src));
    endtask

    initial begin
        int vc;
        RESET = 1'b1;
        {U, V, W, X, Y, Z} = 6'b0;
        CARRIER_PEAK = 1'b0;
        FAULT_CLR    = 1'b0;
        PRM_DEADTIME = 8'd5;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        check_val("rst_duty_u", 32'(DUTY_U), 0);
        check_val("rst_period", 32'(PERIOD), 0);
        check_val("rst_dt_min", 32'(DT_MIN), 32'hff);
        check_val("rst_valid",  32'(VALID), 0);
        check_val("rst_fault",  32'(FAULT), 0);
        check_val("rst_src",    32'(FAULT_SRC), 0);

        // First peak only synchronises.
        run_period(0, 0, 1, -1, -1, -1, -1, -1);
        check_val("first_peak_nvalid", 32'(vcount()), 0);

        run_period(0, 0, 1, -1, -1, -1, -1, -1);
        check_val("p2_nvalid", 32'(vcount()), 1);
        check_pub("p2", 1, 40, 60, 20, 100, 5, 0);
        run_period(0, 0, 1, -1, -1, -1, -1, -1);
        check_pub("p3", 1, 40, 60, 20, 100, 5, 0);

        // Short U->X dead interval of 3 closes at sample 43.
        run_period(0, 1, 1, -1, -1, -1, -1, -1);
        check_val("short_src_before", 32'(lg_src[43]), 0);
        check_val("short_src_set",    32'(lg_src[44]), 2);
        run_period(0, 0, 1, -1, -1, -1, -1, -1);
        check_pub("short", 1, 40, 60, 20, 100, 3, 2);
        run_period(0, 0, 1, -1, 70, -1, -1, -1);
        check_pub("after_short", 1, 40, 60, 20, 100, 5, 2);
        check_val("short_sticky",  32'(lg_src[69]), 2);
        check_val("short_cleared", 32'(lg_src[70]), 0);

        // Shoot-through on V leg at 30 and 40; clear coincides with the second set.
        run_period(0, 0, 1, -1, 41, 50, 30, 40);
        check_val("shoot_src_before", 32'(lg_src[30]), 0);
        check_val("shoot_src_set",    32'(lg_src[31]), 1);
        check_val("shoot_fault_set",  32'(lg_fault[31]), 1);
        check_val("shoot_set_wins",   32'(lg_src[41]), 1);
        check_val("shoot_src_held",   32'(lg_src[49]), 1);
        check_val("shoot_src_clr",    32'(lg_src[50]), 0);
        check_val("shoot_fault_clr",  32'(lg_fault[50]), 0);
        run_period(0, 0, 1, -1, -1, -1, -1, -1);
        check_pub("after_shoot", 1, 40, 60, 20, 100, 5, 0);

        // Carrier stops; last peak was at d=0.
        vc = 0;
        for (int d = 100; d < 400; d++) begin
            drive_cycle(d % NPOS, 0, 0, 1, 0, 0, 0);
            if (VALID) vc++;
            if (d == 254) check_val("ovf_before", 32'(FAULT_SRC), 0);
            if (d == 255) begin
                check_val("ovf_src",   32'(FAULT_SRC), 4);
                check_val("ovf_fault", 32'(FAULT), 1);
            end
        end
        check_val("ovf_no_valid", 32'(vc), 0);
        run_period(0, 0, 1, -1, -1, -1, -1, -1);
        check_val("ovf_resync_nvalid", 32'(vcount()), 0);
        run_period(0, 0, 1, -1, 70, -1, -1, -1);
        check_pub("ovf_recover", 1, 40, 60, 20, 100, 5, 4);
        check_val("ovf_cleared", 32'(lg_src[70]), 0);

        // Reset at cycle 50 of a period.
        run_period(0, 0, 1, 50, -1, -1, -1, -1);
        check_val("mid_rst_duty_u", 32'(lg_duty_u[50]), 0);
        check_val("mid_rst_period", 32'(lg_period[50]), 0);
        check_val("mid_rst_dt_min", 32'(lg_dtmin[50]), 32'hff);
        check_val("mid_rst_valid",  32'(lg_valid[50]), 0);
        check_val("mid_rst_src",    32'(lg_src[50]), 0);
        run_period(0, 0, 1, -1, -1, -1, -1, -1);
        check_val("mid_rst_nvalid", 32'(vcount()), 0);
        run_period(0, 0, 1, -1, -1, -1, -1, -1);
        check_pub("rst_resume", 1, 40, 60, 20, 100, 5, 0);

        // W leg held off.
        run_period(0, 0, 0, -1, -1, -1, -1, -1);
        run_period(0, 0, 0, -1, -1, -1, -1, -1);
        check_pub("wdis_a", 1, 40, 60, 0, 100, 5, 0);
        run_period(0, 0, 0, -1, -1, -1, -1, -1);
        check_pub("wdis_b", 1, 40, 60, 0, 100, 5, 0);

        // Back-to-back peaks at positions 0 and 1.
        run_period(1, 0, 0, -1, -1, -1, -1, -1);
        check_val("b2b_nvalid", 32'(vcount()), 2);
        check_val("b2b_first_period", 32'(lg_period[1]), 100);
        check_pub("b2b", 2, 1, 1, 0, 1, 5, 0);
        run_period(0, 0, 0, -1, -1, -1, -1, -1);
        check_pub("b2b_next", 1, 39, 59, 0, 99, 5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
